// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory; data wins in IDLE, ports alternate under contention.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_byteen_q, mem_byteen_d;
  logic        grant_i, grant_d;
  logic        busy, ack_hit, to_hit, done;
  logic [31:0] rdata_sel;

  assign busy    = (state_q != IDLE);
  assign ack_hit = busy && mem_req_q && mem_ack;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter value is the number of prior unacked BUSY cycles, so the TIMEOUT-th cycle fires.
  assign to_hit = busy && !mem_ack && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i || grant_d) cnt_d = 8'd0;
    else if (busy && !mem_ack) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |8'(TIMEOUT);
  assign to_hit = 1'b0;
`endif

  assign done      = ack_hit || to_hit;
  assign err       = to_hit;
  assign rdata_sel = to_hit ? 32'hDEAD_BEEF : mem_rdata;
  assign i_ready   = (state_q == BUSY_I) && done;
  assign d_ready   = (state_q == BUSY_D) && done;
  assign i_rdata   = i_ready ? rdata_sel : 32'd0;
  assign d_rdata   = d_ready ? rdata_sel : 32'd0;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_byteen_d = mem_byteen_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    // On completion only the other port is considered, forcing alternation.
    case (state_q)
      IDLE: begin
        if (d_req)      grant_d = 1'b1;
        else if (i_req) grant_i = 1'b1;
      end
      BUSY_I: begin
        if (done) begin
          if (d_req) grant_d = 1'b1;
          else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      BUSY_D: begin
        if (done) begin
          if (i_req) grant_i = 1'b1;
          else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (grant_d) begin
      state_d      = BUSY_D;
      mem_req_d    = 1'b1;
      mem_we_d     = d_we;
      mem_addr_d   = d_addr;
      mem_wdata_d  = d_wdata;
      mem_byteen_d = d_byteen;
    end else if (grant_i) begin
      state_d      = BUSY_I;
      mem_req_d    = 1'b1;
      mem_we_d     = 1'b0;
      mem_addr_d   = i_addr;
      mem_wdata_d  = 32'd0;
      mem_byteen_d = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_byteen_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_byteen_q <= mem_byteen_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_byteen = mem_byteen_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions, a monitor pops them on ready.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_byteen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ready, d_ready, mem_req, mem_we, err;
  logic [3:0]  mem_byteen;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_fields(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    chk1({tag, "_mem_req"}, mem_req, 1'b1);
    chk1({tag, "_mem_we"}, mem_we, we);
    chk({tag, "_mem_addr"}, mem_addr, addr);
    chk({tag, "_mem_wdata"}, mem_wdata, wdata);
    chk({tag, "_mem_byteen"}, 32'(mem_byteen), 32'(be));
  endtask

  // Any ready pulse must match the head of the scoreboard; one with nothing pending is an error.
  always @(negedge clk) begin
    exp_t e;
    if (i_ready || d_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: i_ready=%b d_ready=%b with no completion pending (t=%0t)",
                 i_ready, d_ready, $time);
      end else begin
        e = exp_q.pop_front();
        chk1("ready_d", d_ready, e.port);
        chk1("ready_i", i_ready, ~e.port);
        chk("ready_rdata", e.port ? d_rdata : i_rdata, e.data);
        chk("other_rdata", e.port ? i_rdata : d_rdata, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_byteen = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1 reset = 1'b0;
    #2;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_byteen", 32'(mem_byteen), 32'd0);
    chk1("rst_i_ready", i_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk1("rst_err", err, 1'b0);
    step(); step();
    reset = 1'b1;

    // Fetch only
    step();
    i_req = 1'b1; i_addr = 32'h100;
    chk1("f_c0_mem_req", mem_req, 1'b0);
    step();
    chk_fields("f_c1", 1'b0, 32'h100, 32'd0, 4'b1111);
    mem_ack = 1'b1; mem_rdata = 32'hE3A00001;
    expect_done(1'b0, 32'hE3A00001);
    step();
    mem_ack = 1'b0; i_req = 1'b0;
    chk1("f_c2_idle", mem_req, 1'b0);

    // Contention: data first, then fetch with no gap, then fetch again after one idle cycle
    step();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; d_byteen = 4'b0001;
    step();
    chk_fields("c_d", 1'b1, 32'h200, 32'h55, 4'b0001);
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    expect_done(1'b1, 32'h1234);
    step();
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    chk_fields("c_i", 1'b0, 32'h300, 32'd0, 4'b1111);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5;
    expect_done(1'b0, 32'hA5A5);
    step();
    mem_ack = 1'b0;
    chk1("c_repeat_gap", mem_req, 1'b0);
    step();
    chk_fields("c_regrant", 1'b0, 32'h300, 32'd0, 4'b1111);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    expect_done(1'b0, 32'h77);
    step();
    i_req = 1'b0; mem_ack = 1'b0;
    chk1("c_end_idle", mem_req, 1'b0);

`ifndef ARB_TIMEOUT_EN
    // Slow memory: ack in the 5th BUSY cycle, fields changed mid-transfer must be ignored
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = 32'h0; d_byteen = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      d_addr = 32'h999; d_wdata = 32'h1; d_byteen = 4'b0010;
      chk_fields("slow", 1'b0, 32'h400, 32'h0, 4'b1111);
      @(negedge clk);
      chk1("slow_no_ready", d_ready, 1'b0);
      chk1("slow_err", err, 1'b0);
    end
    step();
    chk_fields("slow_ack", 1'b0, 32'h400, 32'h0, 4'b1111);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    expect_done(1'b1, 32'hCAFEF00D);
    step();
    d_req = 1'b0; mem_ack = 1'b0;
    chk1("slow_end_idle", mem_req, 1'b0);
`endif

    // Spurious ack while idle
    step();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk1("sp_i_ready", i_ready, 1'b0);
    chk1("sp_d_ready", d_ready, 1'b0);
    step();
    chk1("sp_mem_req", mem_req, 1'b0);
    mem_ack = 1'b0;

    // Asynchronous reset in the middle of BUSY_D
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hAB; d_byteen = 4'b0011;
    step();
    chk_fields("ar_busy", 1'b1, 32'h500, 32'hAB, 4'b0011);
    #2 reset = 1'b0;
    #1;
    chk1("ar_mem_req", mem_req, 1'b0);
    chk1("ar_mem_we", mem_we, 1'b0);
    chk("ar_mem_addr", mem_addr, 32'd0);
    chk("ar_mem_wdata", mem_wdata, 32'd0);
    chk("ar_mem_byteen", 32'(mem_byteen), 32'd0);
    mem_ack = 1'b1;
    #0;
    chk1("ar_no_d_ready", d_ready, 1'b0);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_addr = 32'h600;
    #1 reset = 1'b1;
    step();
    chk_fields("ar_regrant", 1'b0, 32'h600, 32'd0, 4'b1111);
    mem_ack = 1'b1; mem_rdata = 32'h600D;
    expect_done(1'b0, 32'h600D);
    step();
    i_req = 1'b0; mem_ack = 1'b0;
    chk1("ar_end_idle", mem_req, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no ack times out in the 4th BUSY cycle
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_byteen = 4'b1111; d_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk1("wd_err_early", err, 1'b0);
    end
    step();
    expect_done(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk1("wd_err", err, 1'b1);
    step();
    d_req = 1'b0;
    chk1("wd_idle", mem_req, 1'b0);
    // Ack in the timeout cycle wins
    step();
    i_req = 1'b1; i_addr = 32'h800;
    for (int k = 0; k < 3; k++) step();
    step();
    mem_ack = 1'b1; mem_rdata = 32'h4444;
    expect_done(1'b0, 32'h4444);
    @(negedge clk);
    chk1("wd_ack_wins_err", err, 1'b0);
    step();
    i_req = 1'b0; mem_ack = 1'b0;
    chk1("wd_ack_idle", mem_req, 1'b0);
`endif

    step(); step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_completions: %0d still queued, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
